// File: rtl/cu_edge_data_cache_extract_multi_control_pkg.sv
// Shared types and defaults for the multi-channel cacheline edge-data extractor.
// The stream struct uses the default CU id/data widths.
package cu_edge_data_cache_extract_multi_control_pkg;

  localparam int unsigned CACHELINE_SIZE_BITS_HF = 512;
  localparam int unsigned CACHELINE_SIZE_BITS    = 2 * CACHELINE_SIZE_BITS_HF;

  // One read-response channel per half-line in the original CU.
  localparam int unsigned EXTRACT_NUM_CHANNELS = CACHELINE_SIZE_BITS / CACHELINE_SIZE_BITS_HF;
  localparam int unsigned EXTRACT_FIFO_DEPTH   = 4;

  localparam int unsigned EDGE_ID_BITS   = 32;
  localparam int unsigned EDGE_DATA_BITS = 32;

  typedef struct packed {
    logic [EDGE_ID_BITS-1:0]   id;
    logic [EDGE_DATA_BITS-1:0] data;
  } edge_data_cache_payload_t;

  typedef struct packed {
    logic                     valid;
    edge_data_cache_payload_t payload;
  } edge_data_cache_stream_t;

endpackage

// File: rtl/cu_extract_channel_fifo.sv
// Synchronous beat FIFO for one read-response channel; storage is not reset,
// so an async reset discards contents by clearing pointers and count only.
module cu_extract_channel_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PtrBits = $clog2(Depth);
  localparam int unsigned CntBits = PtrBits + 1;

  logic [Width-1:0]   r_mem [Depth];
  logic [PtrBits-1:0] r_wptr;
  logic [PtrBits-1:0] r_rptr;
  logic [CntBits-1:0] r_count;
  logic               w_wr;
  logic               w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntBits'(Depth));
  assign o_rdata = r_mem[r_rptr];

  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/cu_edge_data_cache_extract_multi_control.sv
// Reassembles a cacheline from NUM_CHANNELS skewed read-response channels and emits one
// {id, element} per line. Data channel k is line slice k from the MSB; tag channel k is at k*TAG_BITS.
module cu_edge_data_cache_extract_multi_control
  import cu_edge_data_cache_extract_multi_control_pkg::*;
#(
  parameter int unsigned CU_ID_X      = 1,
  parameter int unsigned CU_ID_Y      = 1,
  parameter int unsigned NUM_CHANNELS = EXTRACT_NUM_CHANNELS,
  parameter int unsigned LINE_BITS    = 1024,
  parameter int unsigned DATA_BITS    = 32,
  parameter int unsigned ID_BITS      = 32,
  parameter int unsigned TAG_BITS     = 8,
  parameter int unsigned FIFO_DEPTH   = EXTRACT_FIFO_DEPTH,
  parameter int unsigned OFFSET_BITS  = $clog2(LINE_BITS / DATA_BITS)
) (
  input  logic                         clock,
  input  logic                         rstn,
  input  logic                         enabled_in,
  input  logic [NUM_CHANNELS-1:0]      rd_valid_in,
  input  logic [LINE_BITS-1:0]         rd_data_in,
  input  logic [NUM_CHANNELS*TAG_BITS-1:0] rd_tag_in,
  input  logic [OFFSET_BITS-1:0]       rd_offset_in,
  input  logic [ID_BITS-1:0]           rd_id_in,
  output logic                         edge_valid_out,
  input  logic                         edge_ready_in,
  output logic [ID_BITS-1:0]           edge_id_out,
  output logic [DATA_BITS-1:0]         edge_data_out,
  output logic                         err_tag_out,
  output logic [NUM_CHANNELS-1:0]      err_ovf_out
);

  localparam int unsigned SLICE_BITS = LINE_BITS / NUM_CHANNELS;
  localparam int unsigned BEAT_BITS  = SLICE_BITS + TAG_BITS;
  localparam int unsigned SIDE_BITS  = OFFSET_BITS + ID_BITS;
  localparam int unsigned NUM_WORDS  = LINE_BITS / DATA_BITS;

  logic                                   r_enabled;
  logic [NUM_CHANNELS-1:0]                w_push;
  logic [NUM_CHANNELS-1:0]                w_empty;
  logic [NUM_CHANNELS-1:0]                w_full;
  logic [NUM_CHANNELS-1:0]                w_drop;
  logic [NUM_CHANNELS-1:0][TAG_BITS-1:0]  w_head_tag;
  logic [OFFSET_BITS-1:0]                 w_head_offset;
  logic [ID_BITS-1:0]                     w_head_id;
  logic [LINE_BITS-1:0]                   w_line;
  logic [OFFSET_BITS-1:0]                 w_word_idx;
  logic [DATA_BITS-1:0]                   w_element;
  logic                                   w_tag_mismatch;
  logic                                   w_pop;
  logic                                   w_s2_drain;

  logic                 r_s2_valid;
  logic [ID_BITS-1:0]   r_s2_id;
  logic [DATA_BITS-1:0] r_s2_data;
  logic                 r_out_valid;
  logic [ID_BITS-1:0]   r_out_id;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_err_tag;
  logic [NUM_CHANNELS-1:0] r_err_ovf;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) r_enabled <= 1'b0;
    else       r_enabled <= enabled_in;
  end

  // S2 hands off to the output register only while enabled; a pending output
  // handshake still completes when disabled.
  assign w_s2_drain = r_s2_valid && r_enabled && (!r_out_valid || edge_ready_in);
  assign w_pop      = r_enabled && !(|w_empty) && (!r_s2_valid || w_s2_drain);
  assign w_push     = rd_valid_in & {NUM_CHANNELS{r_enabled}};
  assign w_drop     = w_push & w_full & {NUM_CHANNELS{!w_pop}};

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    localparam int unsigned Hi = LINE_BITS - 1 - k * SLICE_BITS;
    if (k == 0) begin : g_lead
      // Channel 0 carries the offset and id alongside its slice.
      logic [BEAT_BITS+SIDE_BITS-1:0] w_wdata;
      logic [BEAT_BITS+SIDE_BITS-1:0] w_rdata;

      assign w_wdata = {rd_offset_in, rd_id_in, rd_tag_in[0 +: TAG_BITS], rd_data_in[Hi -: SLICE_BITS]};

      cu_extract_channel_fifo #(
        .Width (BEAT_BITS + SIDE_BITS),
        .Depth (FIFO_DEPTH)
      ) u_fifo (
        .i_clk   (clock),
        .i_rstn  (rstn),
        .i_push  (w_push[k]),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty[k]),
        .o_full  (w_full[k])
      );

      assign {w_head_offset, w_head_id, w_head_tag[k], w_line[Hi -: SLICE_BITS]} = w_rdata;
    end else begin : g_follow
      logic [BEAT_BITS-1:0] w_wdata;
      logic [BEAT_BITS-1:0] w_rdata;

      assign w_wdata = {rd_tag_in[k*TAG_BITS +: TAG_BITS], rd_data_in[Hi -: SLICE_BITS]};

      cu_extract_channel_fifo #(
        .Width (BEAT_BITS),
        .Depth (FIFO_DEPTH)
      ) u_fifo (
        .i_clk   (clock),
        .i_rstn  (rstn),
        .i_push  (w_push[k]),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty[k]),
        .o_full  (w_full[k])
      );

      assign {w_head_tag[k], w_line[Hi -: SLICE_BITS]} = w_rdata;
    end
  end

  always_comb begin
    w_tag_mismatch = 1'b0;
    for (int k = 1; k < NUM_CHANNELS; k++) begin
      if (w_head_tag[k] != w_head_tag[0]) w_tag_mismatch = 1'b1;
    end
  end

  // Word 0 sits at the line MSB end, so flip the offset before the part-select.
  assign w_word_idx = OFFSET_BITS'(NUM_WORDS - 1) - w_head_offset;
  assign w_element  = w_line[w_word_idx*DATA_BITS +: DATA_BITS];

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_s2_valid  <= 1'b0;
      r_s2_id     <= '0;
      r_s2_data   <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_data  <= '0;
      r_err_tag   <= 1'b0;
      r_err_ovf   <= '0;
    end else begin
      if (w_pop) begin
        r_s2_valid <= 1'b1;
        r_s2_id    <= w_head_id;
        r_s2_data  <= w_element;
      end else if (w_s2_drain) begin
        r_s2_valid <= 1'b0;
      end

      if (w_s2_drain) begin
        r_out_valid <= 1'b1;
        r_out_id    <= r_s2_id;
        r_out_data  <= r_s2_data;
      end else if (edge_ready_in) begin
        r_out_valid <= 1'b0;
      end

      r_err_tag <= r_err_tag | (w_pop & w_tag_mismatch);
      r_err_ovf <= r_err_ovf | w_drop;
    end
  end

  assign edge_valid_out = r_out_valid;
  assign edge_id_out    = r_out_id;
  assign edge_data_out  = r_out_data;
  assign err_tag_out    = r_err_tag;
  assign err_ovf_out    = r_err_ovf;

endmodule

// File: tb/tb_cu_edge_data_cache_extract_multi_control.sv
// Directed bench: a 2-channel/32-bit instance for latency, skew, tags, stall and reset,
// and a 4-channel/64-bit instance for the offset sweep with an enable gap.
module tb_cu_edge_data_cache_extract_multi_control;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstn;

  logic         enabled_in;
  logic [1:0]   rd_valid_in;
  logic [1023:0] rd_data_in;
  logic [15:0]  rd_tag_in;
  logic [4:0]   rd_offset_in;
  logic [31:0]  rd_id_in;
  logic         edge_valid_out;
  logic         edge_ready_in;
  logic [31:0]  edge_id_out;
  logic [31:0]  edge_data_out;
  logic         err_tag_out;
  logic [1:0]   err_ovf_out;

  logic         b_enabled_in;
  logic [3:0]   b_rd_valid_in;
  logic [1023:0] b_rd_data_in;
  logic [31:0]  b_rd_tag_in;
  logic [3:0]   b_rd_offset_in;
  logic [31:0]  b_rd_id_in;
  logic         b_edge_valid_out;
  logic         b_edge_ready_in;
  logic [31:0]  b_edge_id_out;
  logic [63:0]  b_edge_data_out;
  logic         b_err_tag_out;
  logic [3:0]   b_err_ovf_out;

  cu_edge_data_cache_extract_multi_control u_dut (
    .clock          (clock),
    .rstn           (rstn),
    .enabled_in     (enabled_in),
    .rd_valid_in    (rd_valid_in),
    .rd_data_in     (rd_data_in),
    .rd_tag_in      (rd_tag_in),
    .rd_offset_in   (rd_offset_in),
    .rd_id_in       (rd_id_in),
    .edge_valid_out (edge_valid_out),
    .edge_ready_in  (edge_ready_in),
    .edge_id_out    (edge_id_out),
    .edge_data_out  (edge_data_out),
    .err_tag_out    (err_tag_out),
    .err_ovf_out    (err_ovf_out)
  );

  cu_edge_data_cache_extract_multi_control #(
    .NUM_CHANNELS (4),
    .DATA_BITS    (64),
    .FIFO_DEPTH   (4)
  ) u_dut_wide (
    .clock          (clock),
    .rstn           (rstn),
    .enabled_in     (b_enabled_in),
    .rd_valid_in    (b_rd_valid_in),
    .rd_data_in     (b_rd_data_in),
    .rd_tag_in      (b_rd_tag_in),
    .rd_offset_in   (b_rd_offset_in),
    .rd_id_in       (b_rd_id_in),
    .edge_valid_out (b_edge_valid_out),
    .edge_ready_in  (b_edge_ready_in),
    .edge_id_out    (b_edge_id_out),
    .edge_data_out  (b_edge_data_out),
    .err_tag_out    (b_err_tag_out),
    .err_ovf_out    (b_err_ovf_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  int got      = 0;
  logic [63:0] b_got_data [$];
  logic [31:0] b_got_id   [$];
  int          exp_off    [4] = '{0, 7, 8, 15};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wide instance always has ready high, so every valid sample is a distinct element.
  task automatic step();
    @(posedge clock);
    #1;
    if (b_edge_valid_out) begin
      b_got_data.push_back(b_edge_data_out);
      b_got_id.push_back(b_edge_id_out);
    end
  endtask

  function automatic logic [1023:0] line32(input logic [31:0] base);
    logic [1023:0] l;
    l = '0;
    for (int i = 0; i < 32; i++) l[1023-32*i -: 32] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [1023:0] line64(input logic [63:0] base);
    logic [1023:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) l[1023-64*i -: 64] = base + 64'(i);
    return l;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    enabled_in = 1'b0; rd_valid_in = '0; rd_data_in = '0; rd_tag_in = '0;
    rd_offset_in = '0; rd_id_in = '0; edge_ready_in = 1'b1;
    b_enabled_in = 1'b0; b_rd_valid_in = '0; b_rd_data_in = '0; b_rd_tag_in = '0;
    b_rd_offset_in = '0; b_rd_id_in = '0; b_edge_ready_in = 1'b1;
    #1;
    check("reset_valid", edge_valid_out, 0);
    check("reset_data", edge_data_out, 0);
    check("reset_id", edge_id_out, 0);
    check("reset_err_tag", err_tag_out, 0);
    check("reset_err_ovf", err_ovf_out, 0);
    step(); step();
    rstn = 1'b1; enabled_in = 1'b1; b_enabled_in = 1'b1;
    step();

    // Aligned beats: offset 17 of w[i]=i.
    rd_data_in = line32(32'h0); rd_offset_in = 5'd17; rd_id_in = 32'h55; rd_valid_in = 2'b11;
    step(); rd_valid_in = 2'b00;
    step(); check("aligned_early", edge_valid_out, 0);
    step();
    check("aligned_valid", edge_valid_out, 1);
    check("aligned_data", edge_data_out, 17);
    check("aligned_id", edge_id_out, 32'h55);
    step(); check("aligned_consumed", edge_valid_out, 0);

    // Skewed: ch1 three cycles after ch0.
    rd_offset_in = 5'd3; rd_id_in = 32'h77; rd_valid_in = 2'b01;
    step(); rd_valid_in = 2'b00; rd_offset_in = 5'd30; rd_id_in = 32'hdead;
    step(); step(); check("skew_waiting", edge_valid_out, 0);
    rd_valid_in = 2'b10;
    step(); rd_valid_in = 2'b00;
    step(); check("skew_early", edge_valid_out, 0);
    step();
    check("skew_valid", edge_valid_out, 1);
    check("skew_data", edge_data_out, 3);
    check("skew_id", edge_id_out, 32'h77);
    check("skew_err_tag", err_tag_out, 0);
    check("skew_err_ovf", err_ovf_out, 0);
    step(); check("skew_single", edge_valid_out, 0);

    // Tag mismatch: element still emitted, flag set.
    rd_data_in = line32(32'h1000); rd_offset_in = 5'd5; rd_id_in = 32'h99;
    rd_tag_in = {8'h11, 8'h10}; rd_valid_in = 2'b11;
    step(); rd_valid_in = 2'b00; rd_tag_in = '0;
    step(); step();
    check("tag_valid", edge_valid_out, 1);
    check("tag_data", edge_data_out, 32'h1005);
    check("tag_err", err_tag_out, 1);
    step();

    // Backpressure: 8 back-to-back lines, ready low for 10 edges. Out + S2 + 4 FIFO
    // entries hold lines 0..5; lines 6 and 7 are dropped on both channels.
    edge_ready_in = 1'b0;
    for (int j = 0; j < 8; j++) begin
      rd_data_in = line32(32'(j) << 8); rd_offset_in = 5'(j); rd_id_in = 32'h200 + 32'(j);
      rd_valid_in = 2'b11;
      step();
      if (j >= 2) check("bp_hold_data", edge_data_out, 0);
    end
    rd_valid_in = 2'b00;
    step(); step();
    check("bp_hold_valid", edge_valid_out, 1);
    check("bp_hold_data_end", edge_data_out, 0);
    check("bp_hold_id", edge_id_out, 32'h200);
    check("bp_err_ovf", err_ovf_out, 2'b11);
    check("bp_err_tag_sticky", err_tag_out, 1);
    edge_ready_in = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (edge_valid_out) begin
        check("bp_order_data", edge_data_out, 64'((got << 8) + got));
        check("bp_order_id", edge_id_out, 64'(32'h200 + got));
        got++;
      end
      step();
    end
    check("bp_delivered", got, 6);

    // Async reset with an element in the output register and another in flight.
    edge_ready_in = 1'b0;
    rd_data_in = line32(32'h3000); rd_offset_in = 5'd2; rd_id_in = 32'h31; rd_valid_in = 2'b11;
    step(); rd_valid_in = 2'b00;
    step(); step();
    check("rst_pre_data", edge_data_out, 32'h3002);
    rd_offset_in = 5'd4; rd_valid_in = 2'b11;
    step(); rd_valid_in = 2'b00;
    step();
    rstn = 1'b0;
    #1;
    check("rst_valid", edge_valid_out, 0);
    check("rst_data", edge_data_out, 0);
    check("rst_id", edge_id_out, 0);
    check("rst_err_tag", err_tag_out, 0);
    check("rst_err_ovf", err_ovf_out, 0);
    step(); rstn = 1'b1; edge_ready_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("rst_idle", edge_valid_out, 0);
    end
    rd_data_in = line32(32'h4000); rd_offset_in = 5'd9; rd_id_in = 32'h41; rd_valid_in = 2'b11;
    step(); rd_valid_in = 2'b00;
    step(); step();
    check("post_rst_valid", edge_valid_out, 1);
    check("post_rst_data", edge_data_out, 32'h4009);
    step();

    // Wide sweep: 4 channels x 64-bit words, enable dropped for 5 cycles mid-stream.
    b_rd_data_in = line64(64'hC0DE_0000_0000_0000);
    b_rd_offset_in = 4'd0; b_rd_id_in = 32'h500; b_rd_valid_in = 4'hF;
    step();
    b_rd_offset_in = 4'd7; b_rd_id_in = 32'h507;
    step();
    b_rd_valid_in = 4'h0; b_enabled_in = 1'b0;
    for (int c = 0; c < 5; c++) step();
    b_enabled_in = 1'b1;
    step();
    b_rd_offset_in = 4'd8; b_rd_id_in = 32'h508; b_rd_valid_in = 4'hF;
    step();
    b_rd_offset_in = 4'd15; b_rd_id_in = 32'h50F;
    step();
    b_rd_valid_in = 4'h0;
    for (int c = 0; c < 10; c++) step();
    check("wide_count", b_got_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < b_got_data.size()) begin
        check("wide_data", b_got_data[i], 64'hC0DE_0000_0000_0000 + 64'(exp_off[i]));
        check("wide_id", b_got_id[i], 64'(32'h500 + exp_off[i]));
      end
    end
    check("wide_err_tag", b_err_tag_out, 0);
    check("wide_err_ovf", b_err_ovf_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
